// File: rtl/i2c_bus_sequencer_if.sv
// i2c_bus_sequencer_if: bundles the requester side and the i2c_master side of i2c_bus_sequencer
//  master modport: the sequencer's view (drives done/rsp/grant and the m_* transaction)
//  slave  modport: the environment's view (requesters plus the i2c_master)
interface i2c_bus_sequencer_if #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_BITS = 64,
  parameter int MAX_DIN  = 64
);
  logic [NUM_REQ-1:0]          req, req_rw, req_stop, done, grant;
  logic [7*NUM_REQ-1:0]        req_addr;
  logic [5*NUM_REQ-1:0]        req_bytes;
  logic [MAX_BITS*NUM_REQ-1:0] req_data;
  logic [MAX_DIN-1:0]          rsp_data, m_data_in;
  logic                        rsp_error, timeout, m_start, m_rw, m_stop, m_wakeup, m_busy, m_error;
  logic [6:0]                  m_addr;
  logic [4:0]                  m_bytes;
  logic [MAX_BITS-1:0]         m_data_out;
  modport master (
    input  req, req_addr, req_rw, req_bytes, req_stop, req_data, m_busy, m_data_in, m_error,
    output done, rsp_data, rsp_error, grant, timeout,
    output m_start, m_addr, m_rw, m_bytes, m_stop, m_data_out, m_wakeup
  );
  modport slave (
    output req, req_addr, req_rw, req_bytes, req_stop, req_data, m_busy, m_data_in, m_error,
    input  done, rsp_data, rsp_error, grant, timeout,
    input  m_start, m_addr, m_rw, m_bytes, m_stop, m_data_out, m_wakeup
  );
endinterface

// File: rtl/i2c_bus_sequencer.sv
// i2c_bus_sequencer: round-robin arbiter sharing one i2c_master between NUM_REQ requesters
//  clk, rst : system clock, synchronous active-high reset
//  bus      : i2c_bus_sequencer_if.master -- per-requester req/addr/rw/bytes/stop/data in,
//             done/rsp_data/rsp_error/grant/timeout out, m_* handshake to/from i2c_master
//  Optional: define I2C_SEQ_TIMEOUT_EN to bound ISSUE+WAIT to TIMEOUT_CYCLES and wake the master.
module i2c_bus_sequencer #(
  parameter int NUM_REQ        = 4,
  parameter int MAX_BITS       = 64,
  parameter int MAX_DIN        = 64,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input logic clk,
  input logic rst,
  i2c_bus_sequencer_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [2:0] {IDLE, ARB, ISSUE, WAIT, WAKE, DONE} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] last, owner, pick, idx;
  logic expired, to_flag;
  // Scan last+NUM_REQ down to last+1 so the nearest set request after last overwrites the rest.
  always_comb begin
    pick = last;
    idx = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NUM_REQ);
      if (bus.req[idx]) pick = idx;
    end
  end
`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  // to_flag marks a transaction that hit the limit; the WAIT after the wakeup is not counted.
  always_ff @(posedge clk)
    if (rst || state == ARB) begin
      cnt <= '0;
      to_flag <= 1'b0;
    end else begin
      if ((state == ISSUE || state == WAIT) && !to_flag) cnt <= cnt + 1'b1;
      if (state_nxt == WAKE) to_flag <= 1'b1;
    end
  assign expired = (state == ISSUE || state == WAIT) && !to_flag && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign to_flag = 1'b0;
  assign expired = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // IDLE also waits out a master that is still busy from before a reset.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (!bus.m_busy && |bus.req) ? ARB : IDLE;
      ARB:     state_nxt = |bus.req ? ISSUE : IDLE;
      ISSUE:   state_nxt = expired ? WAKE : bus.m_busy ? WAIT : ISSUE;
      WAIT:    state_nxt = !bus.m_busy ? DONE : expired ? WAKE : WAIT;
      WAKE:    state_nxt = bus.m_busy ? WAIT : WAKE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.m_start = state == ISSUE;
    bus.m_wakeup = state == WAKE;
    bus.done = state == DONE ? NUM_REQ'(1) << owner : '0;
    bus.grant = (state == ARB && |bus.req) ? NUM_REQ'(1) << pick :
                (state inside {ISSUE, WAIT, WAKE}) ? NUM_REQ'(1) << owner : '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      last <= IW'(NUM_REQ - 1);
      owner <= '0;
      bus.m_addr <= '0;
      bus.m_rw <= 1'b0;
      bus.m_bytes <= '0;
      bus.m_stop <= 1'b0;
      bus.m_data_out <= '0;
      bus.rsp_data <= '0;
      bus.rsp_error <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      if (state == ARB && |bus.req) begin
        last <= pick;
        owner <= pick;
        bus.m_addr <= bus.req_addr[7*pick +: 7];
        bus.m_rw <= bus.req_rw[pick];
        bus.m_bytes <= bus.req_bytes[5*pick +: 5];
        bus.m_stop <= bus.req_stop[pick];
        bus.m_data_out <= bus.req_data[MAX_BITS*pick +: MAX_BITS];
      end
      if (state == WAIT && !bus.m_busy) begin
        bus.rsp_data <= to_flag ? '0 : bus.m_data_in;
        bus.rsp_error <= to_flag | bus.m_error;
        bus.timeout <= bus.timeout | to_flag;
      end
    end
endmodule

// File: tb/tb_i2c_bus_sequencer.sv
// tb_i2c_bus_sequencer: directed + randomized check of i2c_bus_sequencer against a round-robin model
module tb_i2c_bus_sequencer;
  localparam int N = 4;
  localparam int MB = 64;
  localparam int MD = 64;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  int last_g;
  int own;
  logic [6:0] addr_t[N];
  logic rw_t[N];
  logic [4:0] bytes_t[N];
  logic stop_t[N];
  logic [63:0] data_t[N];
  i2c_bus_sequencer_if #(.NUM_REQ(N), .MAX_BITS(MB), .MAX_DIN(MD)) bus();
  i2c_bus_sequencer #(.NUM_REQ(N), .MAX_BITS(MB), .MAX_DIN(MD), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Round-robin rule: first set request after the last owner, wrapping modulo N.
  function automatic int rr(input int last, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction
  task automatic drive_slots();
    for (int i = 0; i < N; i++) begin
      bus.req_addr[7*i +: 7] = addr_t[i];
      bus.req_rw[i] = rw_t[i];
      bus.req_bytes[5*i +: 5] = bytes_t[i];
      bus.req_stop[i] = stop_t[i];
      bus.req_data[MB*i +: MB] = data_t[i];
    end
  endtask
  task automatic rand_slot(input int i);
    addr_t[i] = 7'($urandom);
    rw_t[i] = 1'($urandom);
    bytes_t[i] = 5'($urandom_range(0, 8));
    stop_t[i] = 1'($urandom);
    data_t[i] = {$urandom, $urandom};
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_start();
    int w = 0;
    while (bus.m_start !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    chk("start_seen", bus.m_start, 1);
  endtask
  // After a done pulse: one idle cycle, then the arbitration cycle shows the new grant.
  task automatic next_arb(output int o);
    step();
    chk("idle_done", bus.done, 0);
    chk("idle_grant", bus.grant, 0);
    step();
    o = rr(last_g, bus.req);
    chk("arb_grant", bus.grant, 64'(1) << o);
  endtask
  task automatic run_txn(input int o, input int d, input int l, input logic [63:0] din,
                         input logic err, input bit scramble);
    wait_start();
    chk("grant", bus.grant, 64'(1) << o);
    chk("m_addr", bus.m_addr, addr_t[o]);
    chk("m_rw", bus.m_rw, rw_t[o]);
    chk("m_bytes", bus.m_bytes, bytes_t[o]);
    chk("m_stop", bus.m_stop, stop_t[o]);
    chk("m_data_out", bus.m_data_out, data_t[o]);
    last_g = o;
    repeat (d) begin
      step();
      chk("start_hold", bus.m_start, 1);
    end
    bus.m_busy = 1'b1;
    step();
    chk("start_drop", bus.m_start, 0);
    if (scramble) begin
      for (int i = 0; i < N; i++) if (i != o) begin
        rand_slot(i);
        bus.req[i] = 1'($urandom);
      end
      if ($urandom_range(0, 3) == 0) bus.req[o] = 1'b0;
      drive_slots();
    end
    repeat (l) step();
    chk("grant_wait", bus.grant, 64'(1) << o);
    chk("addr_wait", bus.m_addr, addr_t[o]);
    chk("start_wait", bus.m_start, 0);
    bus.m_busy = 1'b0;
    bus.m_data_in = din;
    bus.m_error = err;
    step();
    chk("done", bus.done, 64'(1) << o);
    chk("done_grant", bus.grant, 0);
    chk("rsp_data", bus.rsp_data, din);
    chk("rsp_error", bus.rsp_error, err);
  endtask
  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.m_busy = 1'b0;
    bus.m_data_in = '0;
    bus.m_error = 1'b0;
    for (int i = 0; i < N; i++) rand_slot(i);
    drive_slots();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", bus.grant, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_start", bus.m_start, 0);
    chk("rst_wakeup", bus.m_wakeup, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_error", bus.rsp_error, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_m_data_out", bus.m_data_out, 0);
    rst = 1'b0;
    last_g = N - 1;
    addr_t[0] = 7'h48;
    rw_t[0] = 1'b0;
    bytes_t[0] = 5'd2;
    stop_t[0] = 1'b1;
    data_t[0] = 64'hA55A << 48;
    drive_slots();
    bus.req = 4'b0001;
    step();
    chk("lat_arb_start", bus.m_start, 0);
    chk("lat_arb_grant", bus.grant, 1);
    step();
    chk("lat_issue_start", bus.m_start, 1);
    run_txn(0, 3, 4, 64'h0, 1'b0, 0);
    bus.req = '0;
    step();
    chk("done_clear", bus.done, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_g = N - 1;
    for (int i = 0; i < N; i++) rand_slot(i);
    drive_slots();
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_arb(own);
      else own = rr(last_g, bus.req);
      run_txn(own, $urandom_range(0, 2), $urandom_range(0, 3), {$urandom, $urandom}, 1'b0, 0);
    end
    rw_t[2] = 1'b1;
    bytes_t[2] = 5'd2;
    drive_slots();
    bus.req = 4'b0100;
    next_arb(own);
    run_txn(own, 1, 2, 64'h1234, 1'b0, 0);
    bytes_t[3] = 5'd0;
    drive_slots();
    bus.req = 4'b1010;
    next_arb(own);
    run_txn(own, 0, 1, 64'hdead, 1'b1, 0);
    bus.req = 4'b0010;
    next_arb(own);
    run_txn(own, 2, 0, 64'hbeef, 1'b0, 0);
    bus.req = 4'b0001;
    next_arb(own);
    wait_start();
    bus.m_busy = 1'b1;
    step();
    chk("pre_rst_wait", bus.grant, 1);
    rst = 1'b1;
    bus.req = 4'b0011;
    step();
    rst = 1'b0;
    chk("mid_rst_grant", bus.grant, 0);
    chk("mid_rst_start", bus.m_start, 0);
    chk("mid_rst_addr", bus.m_addr, 0);
    chk("mid_rst_rsp_data", bus.rsp_data, 0);
    chk("mid_rst_rsp_error", bus.rsp_error, 0);
    repeat (4) begin
      step();
      chk("busy_hold_start", bus.m_start, 0);
      chk("busy_hold_grant", bus.grant, 0);
    end
    bus.m_busy = 1'b0;
    last_g = N - 1;
    run_txn(rr(last_g, bus.req), 1, 1, 64'h55, 1'b0, 0);
    for (int t = 0; t < 25; t++) begin
      if (bus.req == '0) bus.req[$urandom_range(0, N - 1)] = 1'b1;
      next_arb(own);
      run_txn(own, $urandom_range(0, 3), $urandom_range(0, 5), {$urandom, $urandom}, 1'($urandom), 1);
      bus.req[own] = 1'($urandom);
    end
`ifdef I2C_SEQ_TIMEOUT_EN
    bus.req = 4'b0001;
    next_arb(own);
    wait_start();
    repeat (99) step();
    chk("to_pre_wakeup", bus.m_wakeup, 0);
    chk("to_pre_start", bus.m_start, 1);
    step();
    chk("to_wakeup", bus.m_wakeup, 1);
    chk("to_start_off", bus.m_start, 0);
    bus.m_busy = 1'b1;
    step();
    chk("to_wakeup_off", bus.m_wakeup, 0);
    bus.m_busy = 1'b0;
    bus.m_data_in = 64'hff;
    step();
    chk("to_done", bus.done, 1);
    chk("to_rsp_error", bus.rsp_error, 1);
    chk("to_rsp_data", bus.rsp_data, 0);
    chk("to_flag", bus.timeout, 1);
`else
    chk("no_timeout", bus.timeout, 0);
    chk("no_wakeup", bus.m_wakeup, 0);
`endif
    bus.req = '0;
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
